// File: rtl/opsum_noc_collector_if.sv
// GON FIFO read port plus GLB psum write port, as seen by the opsum collector.
// master = collector side, slave = FIFO/GLB side.
interface opsum_noc_collector_if #(
  parameter int FIFO_IN_WIDTH  = 64,
  parameter int FIFO_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH     = 20
);
  logic                      gon_fifo_empty;
  logic                      re_from_gon_fifo;
  logic [FIFO_IN_WIDTH-1:0]  din;
  logic                      we_to_glb;
  logic [ADDR_WIDTH-1:0]     opsum_addr;
  logic [FIFO_OUT_WIDTH-1:0] dout;

  modport master (
    input  gon_fifo_empty, din,
    output re_from_gon_fifo, we_to_glb, opsum_addr, dout
  );
  modport slave (
    output gon_fifo_empty, din,
    input  re_from_gon_fifo, we_to_glb, opsum_addr, dout
  );
endinterface

// File: rtl/opsum_noc_collector.sv
// Drains packed 64-bit psum words from the GON FIFO and writes them lane by lane
// into the GLB, walking a col/row/ch/img loop nest to form each 4-D address.
module opsum_noc_collector #(
  parameter int E_WIDTH        = 6,
  parameter int F_WIDTH        = 6,
  parameter int m_WIDTH        = 8,
  parameter int n_WIDTH        = 3,
  parameter int e_WIDTH        = 8,
  parameter int p_WIDTH        = 5,
  parameter int t_WIDTH        = 3,
  parameter int FIFO_IN_WIDTH  = 64,
  parameter int FIFO_OUT_WIDTH = 16,
  parameter int ADDR_WIDTH     = 20
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  output logic               busy,
  output logic               done,
  input  logic [m_WIDTH-1:0] channel_base,
  input  logic [E_WIDTH-1:0] row_base,
  input  logic [E_WIDTH-1:0] E,
  input  logic [F_WIDTH-1:0] F,
  input  logic [m_WIDTH-1:0] m,
  input  logic [n_WIDTH-1:0] n,
  input  logic [e_WIDTH-1:0] e,
  input  logic [p_WIDTH-1:0] p,
  input  logic [t_WIDTH-1:0] t,
  opsum_noc_collector_if.master bus
);
  localparam int RATIO  = FIFO_IN_WIDTH / FIFO_OUT_WIDTH;
  localparam int LANE_W = $clog2(RATIO);
  localparam int CH_W   = p_WIDTH + t_WIDTH;

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, WRITE, DONE} state_t;
  state_t state, state_nxt;

  logic [RATIO-1:0][FIFO_OUT_WIDTH-1:0] word_q;
  logic [LANE_W-1:0]  lane;
  logic [F_WIDTH-1:0] col;
  logic [e_WIDTH-1:0] row;
  logic [CH_W-1:0]    ch;
  logic [n_WIDTH-1:0] img;
  logic [CH_W-1:0]    pt;
  logic col_max, row_max, ch_max, img_max, last, zero_dim;
  logic [ADDR_WIDTH-1:0] a_ch, a_row, addr_calc;
  logic re_c, we_c;
  logic [ADDR_WIDTH-1:0]     addr_c;
  logic [FIFO_OUT_WIDTH-1:0] dout_c;

  assign pt       = CH_W'(p) * CH_W'(t);
  assign col_max  = (col == F - F_WIDTH'(1));
  assign row_max  = (row == e - e_WIDTH'(1));
  assign ch_max   = (ch  == pt - CH_W'(1));
  assign img_max  = (img == n - n_WIDTH'(1));
  assign last     = col_max & row_max & ch_max & img_max;
  assign zero_dim = (n == '0) | (p == '0) | (t == '0) | (e == '0) | (F == '0);

  // Address arithmetic is done at ADDR_WIDTH so overflow wraps, not saturates.
  assign a_ch      = ADDR_WIDTH'(img) * ADDR_WIDTH'(m) + ADDR_WIDTH'(channel_base) + ADDR_WIDTH'(ch);
  assign a_row     = a_ch * ADDR_WIDTH'(E) + ADDR_WIDTH'(row_base) + ADDR_WIDTH'(row);
  assign addr_calc = a_row * ADDR_WIDTH'(F) + ADDR_WIDTH'(col);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_q <= '0;
      lane   <= '0;
      col    <= '0;
      row    <= '0;
      ch     <= '0;
      img    <= '0;
    end else begin
      case (state)
        IDLE: begin
          col <= '0;
          row <= '0;
          ch  <= '0;
          img <= '0;
        end
        LOAD: begin
          word_q <= bus.din;
          lane   <= '0;
        end
        WRITE: begin
          lane <= lane + LANE_W'(1);
          if (!col_max) col <= col + F_WIDTH'(1);
          else begin
            col <= '0;
            if (!row_max) row <= row + e_WIDTH'(1);
            else begin
              row <= '0;
              if (!ch_max) ch <= ch + CH_W'(1);
              else begin
                ch  <= '0;
                img <= img + n_WIDTH'(1);
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    re_c      = 1'b0;
    we_c      = 1'b0;
    addr_c    = '0;
    dout_c    = '0;
    case (state)
      IDLE:  if (start) state_nxt = zero_dim ? DONE : FETCH;
      FETCH: begin
        re_c = ~bus.gon_fifo_empty;
        if (!bus.gon_fifo_empty) state_nxt = LOAD;
      end
      LOAD:  state_nxt = WRITE;
      WRITE: begin
        we_c   = 1'b1;
        addr_c = addr_calc;
        dout_c = word_q[lane];
        // Unused lanes of a partial final word are simply dropped.
        if (last)                            state_nxt = DONE;
        else if (lane == LANE_W'(RATIO - 1)) state_nxt = FETCH;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy                 = (state != IDLE);
  assign done                 = (state == DONE);
  assign bus.re_from_gon_fifo = re_c;
  assign bus.we_to_glb        = we_c;
  assign bus.opsum_addr       = addr_c;
  assign bus.dout             = dout_c;
endmodule
